mem_responder: RTL and testbench

Memory-side responder for the CPU's memory bus: accepts one request per transaction (address from MAR, write data from MDR, write strobe, byte enables), runs a fixed wait-state access on an external synchronous SRAM port, and returns read data with a one-cycle ready pulse. It sits between the control unit's MAR/MDR/RAM_LOAD/BYTE_ENABLE outputs and the SRAM, providing the memory cycles that the control unit's M states wait on. Byte lanes are steered and extended here, so the datapath only ever sees 16-bit words.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_lane_steer.sv | 34 +++
 rtl/mem_responder.sv | 107 ++++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-bus definitions: responder states and byte-enable encodings
// (the control unit drives BYTE_ENABLE with the same constants).
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering for SRAM writes and zero-extending lane extraction for reads.
// Byte data always travels in the low byte on the datapath side.
module mem_lane_steer
  import mem_pkg::*;
(
  input  logic [1:0]  wr_be,
  input  logic [15:0] wdata,
  output logic [15:0] wr_data,
  input  logic [1:0]  rd_be,
  input  logic [15:0] sram_rdata,
  output logic [15:0] rd_data
);

  always_comb begin
    wr_data = '0;
    case (wr_be)
      BE_WORD: wr_data = wdata;
      BE_LO:   wr_data = {8'h00, wdata[7:0]};
      BE_HI:   wr_data = {wdata[7:0], 8'h00};
      default: wr_data = '0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (rd_be)
      BE_WORD: rd_data = sram_rdata;
      BE_LO:   rd_data = {8'h00, sram_rdata[7:0]};
      BE_HI:   rd_data = {8'h00, sram_rdata[15:8]};
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request per transaction, fixed wait-state SRAM
// access (SETUP, WAIT_STATES+1 ACCESS cycles), one-cycle ready pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  input  logic [1:0]        be,
  output logic [15:0]       rdata,
  output logic              ready,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic              sram_we,
  output logic              sram_oe,
  output logic [1:0]        sram_be
);

  state_t      state;
  logic [2:0]  cnt;
  logic        we_q;
  logic [1:0]  be_q;
  logic [15:0] wr_steered;
  logic [15:0] rd_extracted;

  // Write steering works on the incoming request so sram_wdata is registered
  // at acceptance; read extraction works on the captured byte enables.
  mem_lane_steer u_lane (
    .wr_be      (be),
    .wdata      (wdata),
    .wr_data    (wr_steered),
    .rd_be      (be_q),
    .sram_rdata (sram_rdata),
    .rd_data    (rd_extracted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      rdata      <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_oe    <= 1'b0;
      sram_be    <= '0;
    end else begin
      ready   <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts exactly like IDLE so back-to-back requests skip IDLE.
          if (req && be == BE_NONE) begin
            state <= DONE;
            ready <= 1'b1;
          end else if (req) begin
            state      <= SETUP;
            busy       <= 1'b1;
            we_q       <= we;
            be_q       <= be;
            sram_addr  <= addr;
            sram_be    <= be;
            sram_wdata <= wr_steered;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          overrun <= req;
          state   <= ACCESS;
          cnt     <= 3'(WAIT_STATES);
          sram_we <= we_q;
          sram_oe <= ~we_q;
        end
        ACCESS: begin
          overrun <= req;
          if (cnt == '0) begin
            state   <= DONE;
            busy    <= 1'b0;
            ready   <= 1'b1;
            sram_we <= 1'b0;
            sram_oe <= 1'b0;
            if (!we_q) rdata <= rd_extracted;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with a byte-lane SRAM model;
// a second instance with WAIT_STATES=0 covers back-to-back throughput.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [15:0] addr, wdata;
  logic [1:0]  be;
  logic [15:0] rdata;
  logic        ready, busy, overrun;
  logic [15:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_we, sram_oe;
  logic [1:0]  sram_be;

  logic        req0;
  logic [15:0] addr0;
  logic [15:0] rdata0;
  logic        ready0, busy0, overrun0;
  logic [15:0] sram_addr0, sram_wdata0, sram_rdata0;
  logic        sram_we0, sram_oe0;
  logic [1:0]  sram_be0;

  logic [15:0] mem [256];

  int tests = 0;
  int fails = 0;
  int lat;
  logic strobe;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(16), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .ready(ready), .busy(busy), .overrun(overrun),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we(sram_we), .sram_oe(sram_oe), .sram_be(sram_be)
  );

  mem_responder #(.ADDR_W(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(1'b0), .addr(addr0), .wdata(16'h0000),
    .be(2'b11), .rdata(rdata0), .ready(ready0), .busy(busy0), .overrun(overrun0),
    .sram_addr(sram_addr0), .sram_wdata(sram_wdata0), .sram_rdata(sram_rdata0),
    .sram_we(sram_we0), .sram_oe(sram_oe0), .sram_be(sram_be0)
  );

  always @(posedge clk) begin
    if (sram_we) begin
      if (sram_be[0]) mem[sram_addr[7:0]][7:0]  <= sram_wdata[7:0];
      if (sram_be[1]) mem[sram_addr[7:0]][15:8] <= sram_wdata[15:8];
    end
  end

  assign sram_rdata  = sram_oe ? mem[sram_addr[7:0]] : 16'h0000;
  assign sram_rdata0 = sram_oe0 ? ~sram_addr0 : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle request in the current cycle; lat is the cycle index
  // (request cycle = 0) in which ready is seen, -1 on timeout.
  task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] b, output int l, output logic s);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    l = -1; s = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) req = 1'b0;
      if (sram_we || sram_oe) s = 1'b1;
      if (ready) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req0 = 1'b0; addr0 = '0;
    step(); step();
    chk("reset_outputs", {rdata, ready, busy, overrun, sram_we, sram_oe, sram_be}, '0);
    chk("reset_sram_bus", {sram_addr, sram_wdata}, '0);
    reset = 1'b0;
    step();

    // Word write, checked cycle by cycle.
    req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'hBEEF; be = 2'b11;
    step(); req = 1'b0;
    chk("wr_c1_setup", {busy, sram_we, sram_oe, ready}, 4'b1000);
    chk("wr_c1_addr_be", {sram_addr, sram_be}, {16'h0010, 2'b11});
    step();
    chk("wr_c2_we", {sram_we, sram_oe, ready}, 3'b100);
    chk("wr_c2_wdata", sram_wdata, 16'hBEEF);
    step();
    chk("wr_c3_we", {sram_we, sram_oe, ready}, 3'b100);
    step();
    chk("wr_c4_ready", {ready, busy, sram_we, sram_oe}, 4'b1000);
    step();
    chk("wr_c5_ready_low", ready, 1'b0);

    txn(1'b0, 16'h0010, 16'h0000, 2'b11, lat, strobe);
    chk("rd_word_latency", lat, 4);
    chk("rd_word_data", rdata, 16'hBEEF);

    // Byte stores into a word, then lane reads.
    txn(1'b1, 16'h0020, 16'h1234, 2'b11, lat, strobe);
    chk("wr_word2_latency", lat, 4);
    txn(1'b1, 16'h0020, 16'h00AA, 2'b01, lat, strobe);
    txn(1'b1, 16'h0020, 16'h0055, 2'b10, lat, strobe);
    chk("wr_hi_latency", lat, 4);
    txn(1'b0, 16'h0020, 16'h0000, 2'b11, lat, strobe);
    chk("rd_merged_word", rdata, 16'h55AA);
    txn(1'b0, 16'h0020, 16'h0000, 2'b10, lat, strobe);
    chk("rd_hi_byte", rdata, 16'h0055);
    txn(1'b0, 16'h0020, 16'h0000, 2'b01, lat, strobe);
    chk("rd_lo_byte", rdata, 16'h00AA);

    // be=00: immediate ready, no strobes, rdata unchanged.
    txn(1'b0, 16'h0020, 16'h0000, 2'b00, lat, strobe);
    chk("be0_rd_latency", lat, 1);
    chk("be0_rd_no_strobe", strobe, 1'b0);
    chk("be0_rd_rdata_held", rdata, 16'h00AA);
    txn(1'b1, 16'h0020, 16'hFFFF, 2'b00, lat, strobe);
    chk("be0_wr_latency", lat, 1);
    chk("be0_wr_no_strobe", strobe, 1'b0);
    txn(1'b0, 16'h0020, 16'h0000, 2'b11, lat, strobe);
    chk("be0_wr_no_change", rdata, 16'h55AA);
    step(); step();

    // Overrun: req during ACCESS is ignored, the pending read completes.
    req = 1'b1; we = 1'b0; addr = 16'h0010; be = 2'b11;
    step(); req = 1'b0;
    step();
    chk("ovr_c2_oe", sram_oe, 1'b1);
    req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h9999;
    step(); req = 1'b0;
    chk("ovr_c3_pulse", {overrun, ready, sram_oe, sram_addr}, {3'b101, 16'h0010});
    step();
    chk("ovr_c4_done", {overrun, ready, rdata}, {2'b01, 16'hBEEF});
    step();
    chk("ovr_c5_idle", {overrun, ready, busy}, 3'b000);
    step();
    chk("ovr_c6_idle", {ready, busy, sram_we}, 3'b000);

    // Back-to-back at WAIT_STATES=0.
    req0 = 1'b1; addr0 = 16'h0003;
    step();
    chk("b2b_c1", {ready0, busy0}, 2'b01);
    step();
    chk("b2b_c2", {ready0, busy0, sram_oe0}, 3'b011);
    step();
    chk("b2b_c3_ready", {ready0, busy0, rdata0}, {2'b10, 16'hFFFC});
    addr0 = 16'h0005;
    step();
    chk("b2b_c4_setup_no_idle", {ready0, busy0, sram_addr0}, {2'b01, 16'h0005});
    step();
    req0 = 1'b0;
    chk("b2b_c5", ready0, 1'b0);
    step();
    chk("b2b_c6_ready", {ready0, rdata0}, {1'b1, 16'hFFFA});
    step();
    chk("b2b_c7_idle", {ready0, busy0}, 2'b00);

    // Reset during a write's ACCESS.
    req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'h7777; be = 2'b11;
    step(); req = 1'b0;
    step();
    chk("rst_c2_we", sram_we, 1'b1);
    reset = 1'b1;
    step();
    chk("rst_outputs", {rdata, ready, busy, overrun, sram_we, sram_oe, sram_be}, '0);
    chk("rst_sram_bus", {sram_addr, sram_wdata}, '0);
    reset = 1'b0;
    strobe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ready || sram_we || sram_oe || busy) strobe = 1'b1;
    end
    chk("rst_no_ready_after", strobe, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
